// File: rtl/bram_1wr_nrd_clr.sv
// ---------------------------------------------------------------------------
// bram_1wr_nrd_clr
//
// Block RAM with one write port, NRD independent registered read ports, and
// a self-clearing sweep. After reset, or after a clear request, the INIT
// state walks a counter over every address and writes zero. It then enters
// RUN and raises ready.
//
// Parameters
//   AWIDTH  address width (depth = 2**AWIDTH)
//   DWIDTH  data word width
//   NRD     number of read ports (1..8)
//   BYPASS  1 = a same-address read in the write cycle returns write_data,
//           0 = that read returns the old contents
//
// Ports
//   clk         single clock, all logic on posedge
//   rst         asynchronous active-high reset
//   write_en    write strobe (ignored while INIT sweeps)
//   write_addr  write address
//   write_data  write word
//   read_en     per-port read strobe, bit i drives port i
//   read_addr   packed read addresses, port i at [i*AWIDTH +: AWIDTH]
//   read_data   packed registered read data, port i at [i*DWIDTH +: DWIDTH]
//   clear       in RUN, restart the zeroing sweep
//   ready       high while the array is initialised (state RUN)
// ---------------------------------------------------------------------------
module bram_1wr_nrd_clr #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_en,
    input  logic [AWIDTH-1:0]     write_addr,
    input  logic [DWIDTH-1:0]     write_data,
    input  logic [NRD-1:0]        read_en,
    input  logic [NRD*AWIDTH-1:0] read_addr,
    output logic [NRD*DWIDTH-1:0] read_data,
    input  logic                  clear,
    output logic                  ready
);

    localparam int  DEPTH     = 2 ** AWIDTH;
    localparam bit  BYPASS_EN = (BYPASS != 0);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state, state_next;
    logic [AWIDTH-1:0]   counter, counter_next;

    logic                mem_we;
    logic [AWIDTH-1:0]   mem_waddr;
    logic [DWIDTH-1:0]   mem_wdata;

    logic [DWIDTH-1:0]   mem [DEPTH];
    logic [DWIDTH-1:0]   rd_q [NRD];
    logic [NRD-1:0]      fwd_hit;

    // ------------------------------------------------------------------
    // State, sweep counter and ready registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples pre-edge values and simulation matches the synthesised flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= INIT;
            counter <= '0;
            ready   <= 1'b0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
            ready   <= (state_next == RUN);
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic and write-port steering
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        mem_we       = 1'b0;
        mem_waddr    = write_addr;
        mem_wdata    = write_data;

        case (state)
            INIT: begin
                // The sweep owns the write port. The counter wraps to zero on
                // its own after the last address.
                mem_we       = 1'b1;
                mem_waddr    = counter;
                mem_wdata    = '0;
                counter_next = counter + AWIDTH'(1);
                if (&counter) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                // A write in the clear cycle still lands. The sweep then
                // overwrites it with zero.
                mem_we = write_en;
                if (clear) begin
                    state_next   = INIT;
                    counter_next = '0;
                end
            end
            default: begin
                state_next   = INIT;
                counter_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage array
    // ------------------------------------------------------------------
    // NOTE: the array has no reset term, so synthesis can map it to block
    // RAM. The zeroing sweep provides the known contents instead. Writes are
    // held off during rst so a stalled sweep cannot touch the array.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    // The forward condition depends only on the write port and the port's own
    // address. Ports that read the same address therefore always agree.
    for (genvar g = 0; g < NRD; g++) begin : g_fwd
        assign fwd_hit[g] = BYPASS_EN && write_en &&
                            (read_addr[g*AWIDTH +: AWIDTH] == write_addr);
        assign read_data[g*DWIDTH +: DWIDTH] = rd_q[g];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NRD; i++) begin
                rd_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NRD; i++) begin
                if (read_en[i]) begin
                    if (state == INIT) begin
                        rd_q[i] <= '0;
                    end else if (fwd_hit[i]) begin
                        rd_q[i] <= write_data;
                    end else begin
                        // The array read sees pre-edge contents, which gives
                        // read-old-data behaviour when forwarding is off.
                        rd_q[i] <= mem[read_addr[i*AWIDTH +: AWIDTH]];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bram_1wr_nrd_clr.sv
// ---------------------------------------------------------------------------
// tb_bram_1wr_nrd_clr
//
// Directed bench for bram_1wr_nrd_clr (AWIDTH=5, DWIDTH=32, NRD=2).
// One instance forwards (BYPASS=1) and one reads old data (BYPASS=0). Both
// share every input. Inputs change on the falling edge and outputs are
// sampled there, half a period away from the active edge.
// ---------------------------------------------------------------------------
module tb_bram_1wr_nrd_clr;

    logic        clk;
    logic        rst;
    logic        write_en;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [1:0]  read_en;
    logic [9:0]  read_addr;
    logic        clear;
    logic [63:0] rdata_bp, rdata_nb;
    logic        ready_bp, ready_nb;

    int n_tests = 0;
    int n_fail  = 0;

    bram_1wr_nrd_clr #(.AWIDTH(5), .DWIDTH(32), .NRD(2), .BYPASS(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_en    (read_en),
        .read_addr  (read_addr),
        .read_data  (rdata_bp),
        .clear      (clear),
        .ready      (ready_bp)
    );

    bram_1wr_nrd_clr #(.AWIDTH(5), .DWIDTH(32), .NRD(2), .BYPASS(0)) dut_nb (
        .clk        (clk),
        .rst        (rst),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_en    (read_en),
        .read_addr  (read_addr),
        .read_data  (rdata_nb),
        .clear      (clear),
        .ready      (ready_nb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Advance clock edges until both instances show ready. Returns the edge
    // count for each, or -1 if ready never rose within the budget. With
    // clear_at > 0, clear is pulsed for that edge (it should be ignored).
    task automatic wait_ready(input int clear_at, output int e_bp, output int e_nb);
        e_bp = -1;
        e_nb = -1;
        for (int i = 1; i <= 40 && (e_bp < 0 || e_nb < 0); i++) begin
            clear = (i == clear_at);
            tick();
            if (ready_bp && e_bp < 0) e_bp = i;
            if (ready_nb && e_nb < 0) e_nb = i;
        end
        clear    = 1'b0;
        write_en = 1'b0;
    endtask

    int e_bp, e_nb;

    initial begin
        rst        = 1'b1;
        write_en   = 1'b0;
        write_addr = '0;
        write_data = '0;
        read_en    = '0;
        read_addr  = '0;
        clear      = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_ready_bp", ready_bp, 0);
        check("rst_rdata_bp", rdata_bp, 0);
        check("rst_ready_nb", ready_nb, 0);
        check("rst_rdata_nb", rdata_nb, 0);

        // Initial sweep: ready rises on edge 32 after release
        rst = 1'b0;
        wait_ready(-1, e_bp, e_nb);
        check("init_edges_bp", e_bp, 32);
        check("init_edges_nb", e_nb, 32);

        // Every address reads zero after the sweep
        read_en = 2'b11;
        for (int a = 0; a < 32; a++) begin
            read_addr = {5'(31 - a), 5'(a)};
            tick();
            check("init_zero_p0", rdata_bp[31:0], 0);
            check("init_zero_p1", rdata_bp[63:32], 0);
        end
        read_en = 2'b00;

        // Basic write then read: port0 addr 3, port1 addr 4
        write_en   = 1'b1;
        write_addr = 5'd3;
        write_data = 32'hDEADBEEF;
        tick();
        write_en  = 1'b0;
        read_en   = 2'b11;
        read_addr = {5'd4, 5'd3};
        tick();
        check("rw_p0", rdata_bp[31:0], 32'hDEADBEEF);
        check("rw_p1", rdata_bp[63:32], 0);
        check("rw_p0_nb", rdata_nb[31:0], 32'hDEADBEEF);

        // Collision: mem[7]=0x11, then write 0x22 to 7 while both ports read 7
        read_en    = 2'b00;
        write_en   = 1'b1;
        write_addr = 5'd7;
        write_data = 32'h11;
        tick();
        write_data = 32'h22;
        read_en    = 2'b11;
        read_addr  = {5'd7, 5'd7};
        tick();
        check("coll_bp_p0", rdata_bp[31:0], 32'h22);
        check("coll_bp_p1", rdata_bp[63:32], 32'h22);
        check("coll_nb_p0", rdata_nb[31:0], 32'h11);
        check("coll_nb_p1", rdata_nb[63:32], 32'h11);
        write_en = 1'b0;
        tick();
        check("coll_after_bp", rdata_bp[31:0], 32'h22);
        check("coll_after_nb", rdata_nb[63:32], 32'h22);

        // Hold: read addr 3, then read_en=0 for 10 cycles while writing addr 3
        read_en   = 2'b01;
        read_addr = {5'd0, 5'd3};
        tick();
        check("hold_load", rdata_bp[31:0], 32'hDEADBEEF);
        read_en    = 2'b00;
        write_en   = 1'b1;
        write_addr = 5'd3;
        for (int k = 0; k < 10; k++) begin
            write_data = 32'h1000 + 32'(k);
            tick();
        end
        write_en = 1'b0;
        check("hold_bp", rdata_bp[31:0], 32'hDEADBEEF);
        check("hold_nb", rdata_nb[31:0], 32'hDEADBEEF);
        read_en = 2'b01;
        tick();
        check("hold_reread", rdata_bp[31:0], 32'h1009);
        read_en = 2'b00;

        // Clear with a same-cycle write of 0x55 to addr 9. During the sweep,
        // write 0xAA to addr 9 (must be ignored) and pulse clear (also ignored).
        clear      = 1'b1;
        write_en   = 1'b1;
        write_addr = 5'd9;
        write_data = 32'h55;
        tick();
        check("clr_ready_low", ready_bp, 0);
        clear      = 1'b0;
        write_data = 32'hAA;
        wait_ready(5, e_bp, e_nb);
        check("clr_edges_bp", e_bp, 32);
        check("clr_edges_nb", e_nb, 32);
        read_en   = 2'b11;
        read_addr = {5'd9, 5'd9};
        tick();
        check("clr_addr9_p0", rdata_bp[31:0], 0);
        check("clr_addr9_p1", rdata_bp[63:32], 0);
        read_addr = {5'd7, 5'd3};
        tick();
        check("clr_addr3", rdata_bp[31:0], 0);
        check("clr_addr7", rdata_bp[63:32], 0);

        // Mid-sweep reset: load a known word into port 0, start a sweep, then
        // assert rst at sweep cycle 10
        read_en    = 2'b00;
        write_en   = 1'b1;
        write_addr = 5'd3;
        write_data = 32'hCAFE0003;
        tick();
        write_en  = 1'b0;
        read_en   = 2'b01;
        read_addr = {5'd0, 5'd3};
        tick();
        check("pre_rst_load", rdata_bp[31:0], 32'hCAFE0003);
        read_en = 2'b00;
        clear   = 1'b1;
        tick();
        clear = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        #1;
        check("async_rst_rd_bp", rdata_bp, 0);
        check("async_rst_rd_nb", rdata_nb, 0);
        check("async_rst_ready", ready_bp, 0);
        tick();
        tick();
        rst = 1'b0;
        wait_ready(-1, e_bp, e_nb);
        check("rst_resweep_bp", e_bp, 32);
        check("rst_resweep_nb", e_nb, 32);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
